// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Op and state encodings, iteration count and decoder funct map.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_STEPS = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } mdu_state_e;

    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1a;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

    // Functs that raise start; mthi/mtlo map one-to-one.
    localparam logic [3:0][5:0] START_FUNCTS = {
        FUNCT_MULTU, FUNCT_MULT, FUNCT_DIVU, FUNCT_DIV
    };

    function automatic logic funct_is_start(input logic [5:0] f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (START_FUNCTS[i] == f) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic op_signed(input logic [1:0] op);
        return op[0];
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mdu_iterative_if.sv
// Pipeline <-> multiply/divide unit connection.
// master = EX stage / hazard side, slave = the MDU.
interface mdu_iterative_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             mthi;
    logic             mtlo;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, A, B, mthi, mtlo,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, A, B, mthi, mtlo,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_negate.sv
// Combinational two's-complement negate.
// Used for operand magnitudes and result sign fix-up.
module mdu_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);
    assign y = ~x + 1'b1;
endmodule

// File: rtl/mdu_iterative.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Fixed 33-cycle latency: 32 radix-2 steps plus one sign fix-up.
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int STEPS = MDU_STEPS
) (
    input  logic           clk,
    input  logic           rst_n,
    mdu_iterative_if.slave bus
);
    localparam int CW = $clog2(STEPS);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    mdu_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   araw_q, araw_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   a_neg, b_neg, rem_neg;
    logic [2*WIDTH-1:0] acc_neg;
    logic               a_sign, b_sign;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_part;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic               unused_ok;

    mdu_negate #(.W(WIDTH)) u_neg_a (
        .x(bus.A),
        .y(a_neg)
    );

    mdu_negate #(.W(WIDTH)) u_neg_b (
        .x(bus.B),
        .y(b_neg)
    );

    mdu_negate #(.W(2*WIDTH)) u_neg_acc (
        .x(acc_q),
        .y(acc_neg)
    );

    mdu_negate #(.W(WIDTH)) u_neg_rem (
        .x(rem_q),
        .y(rem_neg)
    );

    // Operand magnitudes; unsigned ops never take the negated path.
    assign a_sign = op_signed(bus.op) & bus.A[WIDTH-1];
    assign b_sign = op_signed(bus.op) & bus.B[WIDTH-1];
    assign a_mag  = a_sign ? a_neg : bus.A;
    assign b_mag  = b_sign ? b_neg : bus.B;

    // Multiply step: add multiplicand into upper half when lsb set.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opa_q} : '0);

    // Divide step: shift next dividend bit into the partial remainder.
    assign div_part = {rem_q, acc_q[WIDTH-1]};
    assign div_ge   = div_part >= {1'b0, opb_q};
    assign div_diff = div_part - {1'b0, opb_q};

    // When div_ge holds the difference is below the divisor, so its msb is 0.
    assign unused_ok = div_diff[WIDTH];

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            araw_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            araw_q    <= araw_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            done_q    <= done_d;
        end
    end

    // Next-state and datapath: latch, iterate, fix up and commit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        araw_d    = araw_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_CALC;
                    cnt_d     = '0;
                    is_div_d  = op_is_div(bus.op);
                    neg_res_d = a_sign ^ b_sign;
                    neg_rem_d = a_sign;
                    opa_d     = a_mag;
                    opb_d     = b_mag;
                    araw_d    = bus.A;
                    rem_d     = '0;
                    if (op_is_div(bus.op)) begin
                        acc_d = {{WIDTH{1'b0}}, a_mag};
                    end else begin
                        acc_d = {{WIDTH{1'b0}}, b_mag};
                    end
                end else begin
                    if (bus.mthi) hi_d = bus.A;
                    if (bus.mtlo) lo_d = bus.A;
                end
            end
            ST_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div_q) begin
                    rem_d = div_ge ? div_diff[WIDTH-1:0]
                                   : div_part[WIDTH-1:0];
                    acc_d = {acc_q[2*WIDTH-1:WIDTH],
                             acc_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == LAST) state_d = ST_FIX;
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    if (opb_q == '0) begin
                        hi_d = araw_q;
                        lo_d = '1;
                    end else begin
                        hi_d = neg_rem_q ? rem_neg : rem_q;
                        lo_d = neg_res_q ? acc_neg[WIDTH-1:0]
                                         : acc_q[WIDTH-1:0];
                    end
                end else begin
                    hi_d = neg_res_q ? acc_neg[2*WIDTH-1:WIDTH]
                                     : acc_q[2*WIDTH-1:WIDTH];
                    lo_d = neg_res_q ? acc_neg[WIDTH-1:0]
                                     : acc_q[WIDTH-1:0];
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative.
// Vector table plus corner sequences; results checked via scoreboard.
module tb_mdu_iterative;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        string       name;
        logic [63:0] exp;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    sb_t  sb[$];
    sb_t  mon_e;
    vec_t vecs[$];

    mdu_iterative_if #(.WIDTH(32)) bus ();

    mdu_iterative dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb_v;
        logic [63:0] p;
        sa   = longint'($signed(a));
        sb_v = longint'($signed(b));
        case (op)
            2'b00: p = {32'b0, a} * {32'b0, b};
            2'b01: p = 64'(sa * sb_v);
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFFFFFF};
                else if (op == 2'b10) p = {a % b, a / b};
                else p = {32'(sa % sb_v), 32'(sa / sb_v)};
            end
        endcase
        return p;
    endfunction

    // Scoreboard: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                check("spurious done", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check(mon_e.name, {bus.hi, bus.lo}, mon_e.exp);
            end
        end
    end

    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp,
                          input string name, input bit with_mtlo,
                          input bit interfere);
        int cyc;
        bit held;
        logic [63:0] prev;
        sb_t e;
        @(negedge clk);
        prev = {bus.hi, bus.lo};
        bus.op = op;
        bus.A = a;
        bus.B = b;
        bus.start = 1'b1;
        bus.mtlo = with_mtlo;
        e.name = name;
        e.exp = exp;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mtlo = 1'b0;
        bus.op = ~op;
        bus.A = $urandom;
        bus.B = $urandom;
        cyc = 0;
        held = 1'b1;
        while (bus.busy && cyc < 100) begin
            if ({bus.hi, bus.lo} !== prev) held = 1'b0;
            if (interfere && cyc >= 3 && cyc < 6) begin
                bus.start = 1'b1;
                bus.op = 2'b10;
                bus.mthi = 1'b1;
                bus.A = 32'h1234;
                bus.B = 32'd7;
            end else begin
                bus.start = 1'b0;
                bus.mthi = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.start = 1'b0;
        bus.mthi = 1'b0;
        check({name, " hi/lo held while busy"}, 64'(held), 64'd1);
        check({name, " busy cycles"}, 64'(cyc), 64'd33);
        check({name, " done high"}, 64'(bus.done), 64'd1);
        @(posedge clk);
        #1;
        check({name, " done one cycle"}, 64'(bus.done), 64'd0);
        check({name, " idle after"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        vecs.push_back('{"multu max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF,
                         32'hFFFFFFFE, 32'h00000001});
        vecs.push_back('{"mult -7*3", 2'b01, 32'hFFFFFFF9, 32'd3,
                         32'hFFFFFFFF, 32'hFFFFFFEB});
        vecs.push_back('{"div -7/2", 2'b11, 32'hFFFFFFF9, 32'd2,
                         32'hFFFFFFFF, 32'hFFFFFFFD});
        vecs.push_back('{"div min/-1", 2'b11, 32'h80000000, 32'hFFFFFFFF,
                         32'h00000000, 32'h80000000});
        vecs.push_back('{"divu 5/0", 2'b10, 32'd5, 32'd0,
                         32'd5, 32'hFFFFFFFF});
        vecs.push_back('{"div -5/0", 2'b11, 32'hFFFFFFFB, 32'd0,
                         32'hFFFFFFFB, 32'hFFFFFFFF});
        vecs.push_back('{"mult min*min", 2'b01, 32'h80000000, 32'h80000000,
                         32'h40000000, 32'h00000000});
        vecs.push_back('{"mult -1*1", 2'b01, 32'hFFFFFFFF, 32'd1,
                         32'hFFFFFFFF, 32'hFFFFFFFF});
        vecs.push_back('{"divu max/1", 2'b10, 32'hFFFFFFFF, 32'd1,
                         32'h00000000, 32'hFFFFFFFF});
        vecs.push_back('{"div 7/-2", 2'b11, 32'd7, 32'hFFFFFFFE,
                         32'd1, 32'hFFFFFFFD});
        vecs.push_back('{"divu 100/7", 2'b10, 32'd100, 32'd7,
                         32'd2, 32'd14});

        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.A = '0;
        bus.B = '0;
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;

        #2;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset hi/lo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b,
                   {vecs[i].hi, vecs[i].lo}, vecs[i].name, 1'b0, 1'b0);
        end

        @(negedge clk);
        bus.mthi = 1'b1;
        bus.mtlo = 1'b1;
        bus.A = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        check("mthi+mtlo", {bus.hi, bus.lo}, {2{32'hCAFEF00D}});
        check("move busy", 64'(bus.busy), 64'd0);
        check("move done", 64'(bus.done), 64'd0);

        @(negedge clk);
        bus.mthi = 1'b1;
        bus.A = 32'h11112222;
        @(posedge clk);
        #1;
        bus.mthi = 1'b0;
        check("mthi only", {bus.hi, bus.lo}, {32'h11112222, 32'hCAFEF00D});

        run_op(2'b00, 32'd3, 32'd5, 64'd15, "start+mtlo", 1'b1, 1'b0);

        run_op(2'b01, 32'hFFFFFF00, 32'd1000, model(2'b01, 32'hFFFFFF00,
               32'd1000), "start while busy", 1'b0, 1'b1);

        @(negedge clk);
        bus.op = 2'b10;
        bus.A = 32'd1000;
        bus.B = 32'd9;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst busy", 64'(bus.busy), 64'd0);
        check("async rst hi/lo", {bus.hi, bus.lo}, 64'd0);
        check("async rst done", 64'(bus.done), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) begin
                check("no done after reset", {bus.busy, bus.done}, 64'd0);
                break;
            end
        end
        check("quiet after reset", {bus.hi, bus.lo}, 64'd0);

        run_op(2'b10, 32'd1000, 32'd9, {32'd1, 32'd111},
               "divu after reset", 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if (i == 3) rb = 32'd0;
            run_op(rop, ra, rb, model(rop, ra, rb),
                   $sformatf("random %0d", i), 1'b0, 1'b0);
        end

        repeat (2) @(posedge clk);
        check("scoreboard drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
